// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a 2-entry output FIFO.
// Optional SYSTEM-class encoding is enabled by defining INSTR_ENCODER_SYSTEM_EN.
module instr_encoder (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_illegal,
  output logic [15:0] enc_count
);

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  logic        imm_i_ok, imm_b_ok, imm_j_ok;
  logic [31:0] enc_instr;
  logic        enc_ill;
  logic [32:0] enc_word;

  always_comb begin
    enc_instr = '0;
    enc_ill   = 1'b0;
    // Range checks: upper bits must be pure sign extension of the field MSB.
    imm_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    imm_b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    imm_j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    case (in_class)
      4'd0: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_ALU_REG};
      4'd1: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_ALU_IMM};
        else
          enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ALU_IMM};
        enc_ill = ~imm_i_ok;
      end
      4'd2: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        enc_ill = ~imm_b_ok;
      end
      4'd3: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
        enc_ill = ~imm_i_ok | (in_funct3 != 3'b000);
      end
      4'd4: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_ill = ~imm_j_ok;
      end
      4'd5: begin
        enc_instr = {in_imm[31:12], in_rd, OP_AUIPC};
        enc_ill = |in_imm[11:0];
      end
      4'd6: begin
        enc_instr = {in_imm[31:12], in_rd, OP_LUI};
        enc_ill = |in_imm[11:0];
      end
      4'd7: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        enc_ill = ~imm_i_ok;
      end
      4'd8: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        enc_ill = ~imm_i_ok;
      end
`ifdef INSTR_ENCODER_SYSTEM_EN
      4'd9: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_SYSTEM};
        enc_ill = ~imm_i_ok;
      end
`else
      4'd9: enc_ill = 1'b1;
`endif
      default: enc_ill = 1'b1;
    endcase
    enc_word = {enc_ill, (enc_ill ? 32'h0 : enc_instr)};
  end

  logic [32:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [15:0] cnt_q, cnt_d;
  logic        push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};
  assign cnt_d     = cnt_q + {15'd0, push};

  // Head is gated so an empty FIFO always shows a zero word.
  assign out_instr   = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign out_illegal = out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
  assign enc_count   = cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      cnt_q    <= 16'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= enc_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, legality,
// backpressure, async reset and enc_count wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [15:0] enc_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt;
  logic [31:0] exp_sys_instr;
  logic        exp_sys_ill;

  instr_encoder dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_illegal(out_illegal),
    .enc_count  (enc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_class  = cls;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  // One request with out_ready=1: visible one cycle after acceptance, popped the next.
  task automatic run_vec(input string tag, input logic [3:0] cls, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] exp_i, input logic exp_ill);
    drive(cls, rd, rs1, rs2, f3, f7, imm);
    step();
    in_valid = 1'b0;
    exp_cnt  = exp_cnt + 16'd1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, exp_i);
    chk({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    chk({tag, "_cnt"}, {16'd0, enc_count}, {16'd0, exp_cnt});
    $display("txn %s instr=%h illegal=%0b count=%0d", tag, out_instr, out_illegal, enc_count);
    step();
    chk({tag, "_popped"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid  = 1'b0;
    exp_cnt   = 16'd0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_ill", {31'd0, out_illegal}, 32'd0);
    chk("rst_cnt", {16'd0, enc_count}, 32'd0);
    #10 resetn = 1'b1;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    run_vec("addi",     4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    run_vec("jal_2048", 4'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    run_vec("jal_odd",  4'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 32'h0, 1'b1);
    run_vec("add",      4'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
    run_vec("srai",     4'd1, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'd3, 32'h4030_D093, 1'b0);
    run_vec("sw_neg",   4'd8, 5'd0, 5'd2, 5'd3, 3'b010, 7'd0, 32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0);
    run_vec("beq_min",  4'd2, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4096, 32'h8020_8063, 1'b0);
    run_vec("beq_ovr",  4'd2, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096, 32'h0, 1'b1);
    run_vec("lui",      4'd6, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    run_vec("lui_low",  4'd6, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001, 32'h0, 1'b1);
    run_vec("jalr_f3",  4'd3, 5'd1, 5'd2, 5'd0, 3'b001, 7'd0, 32'd0, 32'h0, 1'b1);
    run_vec("addi_ovr", 4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h0, 1'b1);
    run_vec("cls10",    4'd10, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'h0, 1'b1);
`ifdef INSTR_ENCODER_SYSTEM_EN
    exp_sys_instr = 32'h0000_0073;
    exp_sys_ill   = 1'b0;
`else
    exp_sys_instr = 32'h0;
    exp_sys_ill   = 1'b1;
`endif
    run_vec("ecall",    4'd9, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, exp_sys_instr, exp_sys_ill);

    // Backpressure: A and B fill the FIFO, C stalls until space frees.
    out_ready = 1'b0;
    drive(4'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);      // A = 002081B3
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    drive(4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);      // B = 00500093
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    chk("bp_headA", out_instr, 32'h0020_81B3);
    drive(4'd6, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000); // C = 123452B7
    step();
    chk("bp_hold", out_instr, 32'h0020_81B3);
    chk("bp_cnt_hold", {16'd0, enc_count}, {16'd0, exp_cnt});
    $display("txn bp_stall instr=%h ready=%0b count=%0d", out_instr, in_ready, enc_count);
    out_ready = 1'b1;
    step();
    chk("bp_headB", out_instr, 32'h0050_0093);
    chk("bp_nopush", {16'd0, enc_count}, {16'd0, exp_cnt});
    step();
    in_valid = 1'b0;
    exp_cnt  = exp_cnt + 16'd1;
    chk("bp_headC", out_instr, 32'h1234_52B7);
    chk("bp_cntC", {16'd0, enc_count}, {16'd0, exp_cnt});
    $display("txn bp_release instr=%h count=%0d", out_instr, enc_count);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Reset with two entries buffered.
    out_ready = 1'b0;
    drive(4'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
    step();
    step();
    in_valid = 1'b0;
    chk("mid_full", {31'd0, in_ready}, 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_cnt", {16'd0, enc_count}, 32'd0);
    chk("mid_instr", out_instr, 32'd0);
    #3 resetn = 1'b1;
    step();
    chk("mid_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_empty", {31'd0, out_valid}, 32'd0);
    $display("txn mid_reset valid=%0b ready=%0b count=%0d", out_valid, in_ready, enc_count);

    // Counter wrap: one acceptance per cycle with out_ready=1.
    out_ready = 1'b1;
    drive(4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", {16'd0, enc_count}, 32'h0000_FFFF);
    chk("wrap_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("wrap_zero", {16'd0, enc_count}, 32'd0);
    $display("txn wrap count=%0d", enc_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset:
  clk  in  1  rising-edge clock;
  resetn  in  1  async active-low reset.
REQ-002 The block SHALL have these request ports:
  in_valid  in  1  request present;
  in_ready  out  1  request accepted when in_valid&in_ready at clk rise;
  in_class  in  4  0=ALU_REG 1=ALU_IMM 2=BRANCH 3=JALR 4=JAL 5=AUIPC 6=LUI 7=LOAD 8=STORE 9=SYSTEM;
  in_rd, in_rs1, in_rs2  in  5 each  register indices;
  in_funct3  in  3;
  in_funct7  in  7;
  in_imm  in  32  signed byte offset or immediate; U-type uses in_imm[31:12].
REQ-003 The block SHALL have these response ports:
  out_valid  out  1;
  out_ready  in  1;
  out_instr  out  32  encoded word;
  out_illegal  out  1  request not encodable;
  enc_count  out  16  accepted-request counter.

Function
REQ-004 Opcodes SHALL be: ALU_REG 0110011, ALU_IMM 0010011, BRANCH 1100011, JALR 1100111, JAL 1101111, AUIPC 0010111, LUI 0110111, LOAD 0000011, STORE 0100011, SYSTEM 1110011.
REQ-005 Formats SHALL be: ALU_REG R-type; ALU_IMM, JALR, LOAD, SYSTEM I-type; STORE S-type; BRANCH B-type; AUIPC, LUI U-type; JAL J-type. All use standard RV32I bit placement; fields unused by a format are ignored.
REQ-006 ALU_IMM with funct3 001 or 101 SHALL place in_funct7 in bits [31:25] and in_imm[4:0] in bits [24:20].
REQ-007 A request SHALL be illegal if any of the following holds:
  - in_class>9;
  - an I/S immediate is outside -2048..2047;
  - a B immediate is outside -4096..4094 or odd;
  - a J immediate is outside -1048576..1048574 or odd;
  - in_imm[11:0]!=0 for AUIPC or LUI;
  - JALR funct3!=000.
REQ-008 An illegal request SHALL produce out_instr=32'h0000_0000 with out_illegal=1; a legal request SHALL produce out_illegal=0.
REQ-009 Encoding SHALL be registered into a 2-entry FIFO; an entry accepted at edge N SHALL be visible at out_valid no earlier than after edge N, with minimum latency 1 cycle.
REQ-010 in_ready SHALL equal "FIFO not full"; it SHALL NOT depend combinationally on out_ready.
REQ-011 Output SHALL pop on out_valid&out_ready; out_instr and out_illegal SHALL be stable while out_valid=1 and out_ready=0.
REQ-012 A simultaneous push and pop with 1 entry SHALL keep occupancy at 1, with ordering preserved (FIFO).
REQ-013 With the FIFO full, in_ready=0 and a pop in the same cycle SHALL NOT admit a push that cycle.
REQ-014 enc_count SHALL increment on every accepted request, legal or illegal, and wrap 16'hFFFF->0.

Reset
REQ-015 On resetn low, the FIFO SHALL empty immediately and enc_count SHALL clear.
REQ-016 Reset output values SHALL be: out_valid=0, out_instr=0, out_illegal=0, enc_count=0; in_ready=1 after release.
REQ-017 Reset asserted mid-transfer SHALL discard all buffered entries; no partial entry survives.

Configuration
REQ-018 With macro INSTR_ENCODER_SYSTEM_EN defined, class 9 SHALL encode as an I-type SYSTEM word.
REQ-019 With INSTR_ENCODER_SYSTEM_EN undefined, class 9 SHALL be illegal per REQ-008.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - ALU_IMM rd=1 rs1=0 f3=000 imm=5, out_ready=1 -> out_instr=32'h0050_0093, out_illegal=0, one cycle later.
  - JAL rd=1 imm=2048 -> 32'h0010_00EF; JAL imm=3 -> out_illegal=1, out_instr=0.
  - out_ready=0, three requests offered -> two accepted, in_ready=0; release out_ready -> outputs in order, third accepted.
  - SYSTEM funct3=000 imm=0 -> 32'h0000_0073 with INSTR_ENCODER_SYSTEM_EN defined; out_illegal=1 without it.
  - Reset pulsed with 2 entries buffered -> out_valid=0 asynchronously, enc_count=0, in_ready=1 after release.
  - 65536 accepted requests -> enc_count wraps to 0.
